vrf_port_arbiter: RTL and testbench

- Round-robin arbiter that shares one port of the byte-write vector register file RAM (NUM_COL x COL_WIDTH, 1-cycle registered read) among N_REQ requesters, e.g. ALU writeback, load unit, store-data read, and scalar move.
- Issues at most one RAM command per cycle through a registered command stage.
- Tracks in-flight reads and returns read data tagged with the requester ID.
- Sits between the vector issue logic and the RAM's port A (or port B) pins.

---
 rtl/vrf_port_arbiter.sv | 122 ++++++++++++
 tb/tb_vrf_port_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vrf_port_arbiter.sv
// Round-robin arbiter sharing one byte-write VRF RAM port among N_REQ requesters.
// Registered command stage, read tracking, and ID-tagged read responses two cycles after handshake.
module vrf_port_arbiter #(
  parameter int N_REQ      = 4,
  parameter int NUM_COL    = 8,
  parameter int COL_WIDTH  = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = NUM_COL * COL_WIDTH,
  parameter int ID_W       = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        stall,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ*NUM_COL-1:0]    req_we,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic                        ram_en,
  output logic [NUM_COL-1:0]          ram_we,
  output logic [ADDR_WIDTH-1:0]       ram_addr,
  output logic [DATA_WIDTH-1:0]       ram_din,
  input  logic [DATA_WIDTH-1:0]       ram_dout,
  output logic                        rsp_valid,
  output logic [ID_W-1:0]             rsp_id,
  output logic [DATA_WIDTH-1:0]       rsp_data
);

  localparam int PAD = 2 ** ID_W;
  localparam int SW  = ID_W + 1;

  logic [ID_W-1:0]       ptr;
  logic [ID_W-1:0]       ptr_nxt;
  logic [ID_W-1:0]       grant_idx;
  logic                  grant_any;
  logic                  grant_read;
  logic [PAD-1:0]        valid_pad;
  logic [NUM_COL-1:0]    sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_din;
  logic                  rd_pend;
  logic [ID_W-1:0]       rd_id;

  // Padding to a power of two lets an ID_W-bit slot index the valid vector directly.
  assign valid_pad = PAD'(req_valid);

  always_comb begin : arbitrate
    logic [SW-1:0] slot;
    grant_any = 1'b0;
    grant_idx = '0;
    slot      = '0;
    if (rst_n && !stall) begin
      for (int k = 0; k < N_REQ; k++) begin
        slot = {1'b0, ptr} + SW'(k);
        if (slot >= SW'(N_REQ)) slot = slot - SW'(N_REQ);
        if (!grant_any && valid_pad[slot[ID_W-1:0]]) begin
          grant_any = 1'b1;
          grant_idx = slot[ID_W-1:0];
        end
      end
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
    assign req_ready[gi] = grant_any && (grant_idx == ID_W'(gi));
  end

  // Explicit wrap so non-power-of-two N_REQ never lands on an unused index.
  assign ptr_nxt = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

  always_comb begin : select_cmd
    sel_we   = '0;
    sel_addr = '0;
    sel_din  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_we   = req_we[i*NUM_COL +: NUM_COL];
        sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_din  = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign grant_read = (sel_we == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr      <= '0;
      ram_en   <= 1'b0;
      ram_we   <= '0;
      ram_addr <= '0;
      ram_din  <= '0;
      rd_pend  <= 1'b0;
      rd_id    <= '0;
    end else begin
      ram_en  <= grant_any;
      rd_pend <= grant_any && grant_read;
      if (grant_any) begin
        ptr      <= ptr_nxt;
        ram_we   <= sel_we;
        ram_addr <= sel_addr;
        ram_din  <= sel_din;
        if (grant_read) rd_id <= grant_idx;
      end else begin
        ram_we <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
    end else begin
      rsp_valid <= rd_pend;
      rsp_id    <= rd_id;
    end
  end

  assign rsp_data = ram_dout;

endmodule

// File: tb/tb_vrf_port_arbiter.sv
// Bench for vrf_port_arbiter: directed scenarios with literal expectations plus a randomized run
// checked every cycle against a behavioural model (grant rule, command copy, response queue, memory).
module tb_vrf_port_arbiter;

  localparam int N  = 4;
  localparam int NC = 8;
  localparam int AW = 10;
  localparam int DW = 64;
  localparam int IW = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            stall;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*NC-1:0] req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic            ram_en;
  logic [NC-1:0]   ram_we;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_din;
  logic [DW-1:0]   ram_dout;
  logic            rsp_valid;
  logic [IW-1:0]   rsp_id;
  logic [DW-1:0]   rsp_data;

  // second instance with three requesters
  logic           stall3;
  logic [2:0]     v3_valid;
  logic [2:0]     v3_ready;
  logic [23:0]    v3_we;
  logic [29:0]    v3_addr;
  logic [191:0]   v3_wdata;
  logic           ram3_en;
  logic [7:0]     ram3_we;
  logic [AW-1:0]  ram3_addr;
  logic [DW-1:0]  ram3_din;
  logic [DW-1:0]  ram3_dout;
  logic           rsp3_valid;
  logic [1:0]     rsp3_id;
  logic [DW-1:0]  rsp3_data;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  vrf_port_arbiter #(.N_REQ(N), .NUM_COL(NC), .COL_WIDTH(8), .ADDR_WIDTH(AW), .ID_W(IW)) u_dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data));

  vrf_port_arbiter #(.N_REQ(3), .NUM_COL(NC), .COL_WIDTH(8), .ADDR_WIDTH(AW), .ID_W(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .stall(stall3), .req_valid(v3_valid), .req_ready(v3_ready),
    .req_we(v3_we), .req_addr(v3_addr), .req_wdata(v3_wdata),
    .ram_en(ram3_en), .ram_we(ram3_we), .ram_addr(ram3_addr), .ram_din(ram3_din), .ram_dout(ram3_dout),
    .rsp_valid(rsp3_valid), .rsp_id(rsp3_id), .rsp_data(rsp3_data));

  function automatic logic [DW-1:0] init_word(input int a);
    if (a == 5) return 64'h0000_0000_0000_00A5;
    if (a == 3) return 64'hDEAD_BEEF_CAFE_F00D;
    return {32'h0BAD_0000 | 32'(a), 32'h1234_5678 ^ 32'(a)};
  endfunction

  // RAM behind the port: byte writes, one-cycle registered read
  logic [DW-1:0] ram_mem [16];
  initial begin
    ram_dout <= '0;
    for (int a = 0; a < 16; a++) ram_mem[a] <= init_word(a);
  end
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we == '0) ram_dout <= ram_mem[ram_addr[3:0]];
      else for (int b = 0; b < NC; b++)
        if (ram_we[b]) ram_mem[ram_addr[3:0]][b*8 +: 8] <= ram_din[b*8 +: 8];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {int due; int id; logic [DW-1:0] data;} rsp_t;
  rsp_t          rspq[$];
  logic [DW-1:0] mmem [16];
  int            m_ptr  = 0;
  logic          e_en   = 1'b0;
  logic [NC-1:0] e_we   = '0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_din  = '0;

  function automatic int model_grant();
    if (!rst_n || stall) return -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (req_valid[j]) return j;
    end
    return -1;
  endfunction

  initial begin
    int            g;
    logic [N-1:0]  exp_ready;
    logic          rv;
    logic [NC-1:0] we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int i = 0; i < 16; i++) mmem[i] = init_word(i);
    @(posedge clk);
    forever begin
      @(negedge clk);
      cyc++;
      g = model_grant();
      exp_ready = (g >= 0) ? N'(1) << g : '0;
      chk("ready", 64'(req_ready), 64'(exp_ready));
      chk("ram_en", 64'(ram_en), 64'(e_en));
      chk("ram_we", 64'(ram_we), 64'(e_we));
      chk("ram_addr", 64'(ram_addr), 64'(e_addr));
      chk("ram_din", ram_din, e_din);
      rv = (rspq.size() > 0) && (rspq[0].due == cyc);
      chk("rsp_valid", 64'(rsp_valid), 64'(rv));
      if (rv) begin
        chk("rsp_id", 64'(rsp_id), 64'(rspq[0].id));
        chk("rsp_data", rsp_data, rspq[0].data);
        void'(rspq.pop_front());
      end
      if (!rst_n) begin
        m_ptr = 0; e_en = 0; e_we = '0; e_addr = '0; e_din = '0;
        rspq.delete();
      end else if (g >= 0) begin
        we = req_we[g*NC +: NC];
        a  = req_addr[g*AW +: AW];
        d  = req_wdata[g*DW +: DW];
        e_en = 1; e_we = we; e_addr = a; e_din = d;
        m_ptr = (g + 1) % N;
        if (we == '0) rspq.push_back('{cyc + 2, g, mmem[a[3:0]]});
        else for (int b = 0; b < NC; b++) if (we[b]) mmem[a[3:0]][b*8 +: 8] = d[b*8 +: 8];
      end else begin
        e_en = 0; e_we = '0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [NC-1:0] we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_we[i*NC +: NC]  = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  initial begin
    logic [N-1:0] one_hot;
    rst_n = 0; stall = 0; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    stall3 = 0; v3_valid = '0; v3_we = '0; v3_wdata = '0; ram3_dout = '0;
    v3_addr = {10'h12, 10'h11, 10'h10};
    next_cycle();
    req_valid = 4'hF;
    @(negedge clk);
    chk("lit_reset_ready", 64'(req_ready), 64'h0);
    chk("lit_reset_ram_en", 64'(ram_en), 64'h0);
    chk("lit_reset_rsp_valid", 64'(rsp_valid), 64'h0);
    next_cycle();
    rst_n = 1; req_valid = '0;

    // single read by requester 2 at address 5
    req_valid = 4'b0100; set_req(2, '0, 10'h05, {$urandom, $urandom});
    @(negedge clk); chk("lit_rd_ready", 64'(req_ready), 64'b0100);
    next_cycle(); req_valid = '0;
    @(negedge clk); chk("lit_rd_ram_en", 64'(ram_en), 64'h1); chk("lit_rd_ram_addr", 64'(ram_addr), 64'h05);
    next_cycle();
    @(negedge clk);
    chk("lit_rd_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("lit_rd_rsp_id", 64'(rsp_id), 64'h2);
    chk("lit_rd_rsp_data", rsp_data, 64'hA5);

    // partial write by requester 0, then read-after-write by requester 1
    next_cycle();
    req_valid = 4'b0001; set_req(0, 8'h0F, 10'h03, 64'h1122_3344_5566_7788);
    @(negedge clk); chk("lit_wr_ready", 64'(req_ready), 64'b0001);
    next_cycle();
    req_valid = 4'b0010; set_req(1, '0, 10'h03, {$urandom, $urandom});
    @(negedge clk); chk("lit_raw_ready", 64'(req_ready), 64'b0010); chk("lit_wr_ram_we", 64'(ram_we), 64'h0F);
    next_cycle(); req_valid = '0;
    next_cycle();
    @(negedge clk);
    chk("lit_raw_rsp_id", 64'(rsp_id), 64'h1);
    chk("lit_raw_rsp_data", rsp_data, 64'hDEAD_BEEF_5566_7788);

    // all four valid from reset: grants 0,1,2,3,0,1
    next_cycle(); rst_n = 0;
    next_cycle(); rst_n = 1; req_valid = 4'hF;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++) set_req(i, '0, AW'($urandom_range(0, 7)), {$urandom, $urandom});
      one_hot = N'(1) << (k % 4);
      @(negedge clk); chk("lit_rr_ready", 64'(req_ready), 64'(one_hot));
      next_cycle();
    end

    // stall with requesters 1 and 3 pending while a read from requester 0 is in flight
    req_valid = 4'b0001; set_req(0, '0, 10'h05, {$urandom, $urandom});
    @(negedge clk); chk("lit_pre_stall_ready", 64'(req_ready), 64'b0001);
    next_cycle();
    stall = 1; req_valid = 4'b1010;
    set_req(1, '0, 10'h01, {$urandom, $urandom}); set_req(3, '0, 10'h02, {$urandom, $urandom});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); chk("lit_stall_ready", 64'(req_ready), 64'h0);
      if (k == 1) begin
        chk("lit_stall_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("lit_stall_rsp_id", 64'(rsp_id), 64'h0);
      end
      next_cycle();
    end
    stall = 0;
    @(negedge clk); chk("lit_unstall_first", 64'(req_ready), 64'b0010);
    next_cycle();
    @(negedge clk); chk("lit_unstall_second", 64'(req_ready), 64'b1000);
    next_cycle(); req_valid = '0;

    // reset on the cycle after a read grant
    req_valid = 4'b0100; set_req(2, '0, 10'h04, {$urandom, $urandom});
    @(negedge clk); chk("lit_prerst_ready", 64'(req_ready), 64'b0100);
    next_cycle(); rst_n = 0; req_valid = '0;
    @(negedge clk); chk("lit_midrst_ram_en", 64'(ram_en), 64'h1);
    next_cycle(); rst_n = 1; req_valid = 4'hF;
    @(negedge clk);
    chk("lit_postrst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("lit_postrst_ready", 64'(req_ready), 64'b0001);
    next_cycle(); req_valid = '0;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      stall = ($urandom_range(0, 4) == 0);
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++)
        set_req(i, $urandom_range(0, 1) ? NC'(0) : NC'($urandom), AW'($urandom_range(0, 15)), {$urandom, $urandom});
      next_cycle();
    end
    rst_n = 1; stall = 0; req_valid = '0;
    next_cycle();

    // three requesters: 0 and 2 alternate, then all three rotate
    v3_valid = 3'b101;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("lit_n3_alt_ready", 64'(v3_ready), (k % 2 == 0) ? 64'b001 : 64'b100);
      if (k > 0) chk("lit_n3_ram_addr", 64'(ram3_addr), (k % 2 == 0) ? 64'h12 : 64'h10);
      next_cycle();
    end
    v3_valid = 3'b111;
    for (int k = 0; k < 4; k++) begin
      one_hot = N'(1) << (k % 3);
      @(negedge clk); chk("lit_n3_rot_ready", 64'(v3_ready), 64'(one_hot[2:0]));
      next_cycle();
    end
    v3_valid = '0;
    next_cycle();
    next_cycle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
